// File: rtl/svi_reg_arbiter.sv
// Round-robin arbiter that lets NREQ requesters write a shared 3-bit {z,y,x}
// register. A requester can lock the grant, and the lock is released if the owner stays idle too long.
module svi_reg_arbiter #(
   parameter int NREQ         = 3,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic                    i_clk,
   input  logic                    i_arst,
   input  logic                    i_srst,
   input  logic [NREQ-1:0]         i_req_valid,
   input  logic [NREQ-1:0]         i_req_lock,
   input  logic [3*NREQ-1:0]       i_req_data,
   input  logic [3*NREQ-1:0]       i_req_mask,
   output logic [NREQ-1:0]         o_req_ready,
   output logic                    o_z,
   output logic                    o_y,
   output logic                    o_x,
   output logic [$clog2(NREQ)-1:0] o_grant_idx,
   output logic                    o_busy,
   output logic                    o_timeout,
   output logic [7:0]              o_wr_count
);

   // state     | meaning
   // ST_ARB    | round-robin arbitration starting at ptr
   // ST_LOCKED | only owner may write; idle cycles counted toward forced release
   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam int         IW        = $clog2(NREQ);
   localparam logic [7:0] IDLE_LAST = 8'(LOCK_TIMEOUT - 1);

   logic [0:0]    state;
   logic [IW-1:0] owner;
   logic [IW-1:0] ptr;
   logic [7:0]    idle_cnt;

   logic [NREQ-1:0] ready_c;
   logic            found;
   int              idx;

   logic            acc_vld;
   logic [IW-1:0]   acc_idx;
   logic            acc_lock;
   logic [2:0]      acc_data;
   logic [2:0]      acc_mask;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
      if (int'(k) == NREQ - 1) return '0;
      else                     return k + 1'b1;
   endfunction

   always_comb begin
      ready_c = '0;
      found   = 1'b0;
      idx     = 0;
      if (!i_srst) begin
         if (state == ST_LOCKED) begin
            ready_c[owner] = i_req_valid[owner];
         end else begin
            for (int i = 0; i < NREQ; i++) begin
               idx = int'(ptr) + i;
               if (idx >= NREQ) idx = idx - NREQ;
               if (!found && i_req_valid[idx]) begin
                  found        = 1'b1;
                  ready_c[idx] = 1'b1;
               end
            end
         end
      end
   end

   assign o_req_ready = ready_c;
   assign o_busy      = (state == ST_LOCKED);

   always_comb begin
      acc_vld  = 1'b0;
      acc_idx  = '0;
      acc_lock = 1'b0;
      acc_data = '0;
      acc_mask = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (ready_c[k] && i_req_valid[k]) begin
            acc_vld  = 1'b1;
            acc_idx  = IW'(k);
            acc_lock = i_req_lock[k];
            acc_data = i_req_data[3*k +: 3];
            acc_mask = i_req_mask[3*k +: 3];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state       <= ST_ARB;
         owner       <= '0;
         ptr         <= '0;
         idle_cnt    <= '0;
         o_z         <= 1'b0;
         o_y         <= 1'b0;
         o_x         <= 1'b0;
         o_grant_idx <= '0;
         o_timeout   <= 1'b0;
         o_wr_count  <= '0;
      end else if (i_srst) begin
         state       <= ST_ARB;
         owner       <= '0;
         ptr         <= '0;
         idle_cnt    <= '0;
         o_z         <= 1'b0;
         o_y         <= 1'b0;
         o_x         <= 1'b0;
         o_grant_idx <= '0;
         o_timeout   <= 1'b0;
         o_wr_count  <= '0;
      end else begin
         o_timeout <= 1'b0;
         if (acc_vld) begin
            if (acc_mask[2]) o_z <= acc_data[2];
            if (acc_mask[1]) o_y <= acc_data[1];
            if (acc_mask[0]) o_x <= acc_data[0];
            o_grant_idx <= acc_idx;
            o_wr_count  <= o_wr_count + 8'd1;
         end
         case (state)
            ST_ARB: begin
               if (acc_vld) begin
                  if (acc_lock) begin
                     state    <= ST_LOCKED;
                     owner    <= acc_idx;
                     idle_cnt <= '0;
                  end else begin
                     ptr <= next_idx(acc_idx);
                  end
               end
            end
            default: begin
               // In LOCKED any accepted beat is necessarily the owner's
               if (acc_vld) begin
                  idle_cnt <= '0;
                  if (!acc_lock) begin
                     state <= ST_ARB;
                     ptr   <= next_idx(owner);
                  end
               end else if (idle_cnt == IDLE_LAST) begin
                  state     <= ST_ARB;
                  ptr       <= next_idx(owner);
                  idle_cnt  <= '0;
                  o_timeout <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/svi_reg_arbiter.md
SVI_REG_ARBITER -- requirements
Module: svi_reg_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters, legal range 2..8.
REQ-002 Parameter LOCK_TIMEOUT, default 16: idle cycles allowed while locked before forced release, legal range 2..255.
REQ-003 i_clk  input  1  clock; all state changes on posedge.
REQ-004 i_arst  input  1  reset, asynchronous, active-high.
REQ-005 i_srst  input  1  synchronous clear, active-high.
REQ-006 i_req_valid  input  NREQ  per-requester write request.
REQ-007 i_req_lock  input  NREQ  per-requester hold-grant flag, sampled only on an accepted beat.
REQ-008 i_req_data  input  3*NREQ  per-requester {z,y,x}; requester k uses bits [3k+2:3k].
REQ-009 i_req_mask  input  3*NREQ  per-requester field write enables, same packing as i_req_data.
REQ-010 o_req_ready  output  NREQ  combinational grant; at most one bit set.
REQ-011 o_z, o_y, o_x  output  1 each  the shared register fields.
REQ-012 o_grant_idx  output  $clog2(NREQ)  index of the last accepted requester.
REQ-013 o_busy  output  1  high while in LOCKED.
REQ-014 o_timeout  output  1  single-cycle pulse on forced lock release.
REQ-015 o_wr_count  output  8  count of accepted beats, modulo 256.

Function
REQ-016 A beat from requester k shall be accepted when i_req_valid[k] and o_req_ready[k] are both high in the same cycle.
REQ-017 o_req_ready shall be all-zero when i_srst is high.
REQ-018 FSM states are ARB and LOCKED; owner is a $clog2(NREQ)-bit register; ptr is the round-robin pointer.
REQ-019 In ARB, ready shall go to the first valid requester found scanning ptr, ptr+1, ... modulo NREQ; no valid requester means no ready.
REQ-020 In LOCKED, only the owner may receive ready, and only when its valid is high.
REQ-021 On an accepted beat, each o_z/o_y/o_x field whose mask bit is 1 shall take the data bit at the next edge (1-cycle latency); unmasked fields hold.
REQ-022 An accepted beat with an all-zero mask shall still count and still apply the lock rules.
REQ-023 On an accepted beat, o_grant_idx shall become k and o_wr_count shall increment, wrapping 255->0.
REQ-024 ARB->LOCKED shall occur on an accepted beat with lock=1; owner<=k; ptr unchanged.
REQ-025 An accepted beat with lock=0 in ARB shall set ptr<=(k+1) mod NREQ.
REQ-026 In LOCKED, an accepted owner beat with lock=1 shall stay LOCKED and clear the idle counter.
REQ-027 In LOCKED, an accepted owner beat with lock=0 shall set the state to ARB and ptr<=(owner+1) mod NREQ.
REQ-028 In LOCKED, each cycle without an owner beat shall increment the idle counter.
REQ-029 When the idle counter reaches LOCK_TIMEOUT-1 and no owner beat occurs, the block shall go to ARB, set ptr<=(owner+1) mod NREQ, and pulse o_timeout for one cycle.
REQ-030 Requests from non-owners while LOCKED shall be held off without loss; requesters keep valid asserted until ready.
REQ-031 Simultaneous valids shall be resolved by REQ-019 only; there is no fixed priority.

Reset
REQ-032 On i_arst the block shall immediately set o_z=o_y=o_x=0, state=ARB, ptr=0, owner=0, idle counter=0, o_grant_idx=0, o_busy=0, o_timeout=0, o_wr_count=0.
REQ-033 i_srst high at an edge shall load the same values as REQ-032, override any accepted beat, and may abort LOCKED mid-operation.
REQ-034 Reset shall never produce an o_timeout pulse.

Verification
REQ-035 After reset, all NREQ=3 valids held high with lock=0, mask=111 and data k-specific: grants shall go 0,1,2,0,... one per cycle, and o_wr_count=4 after 4 cycles.
REQ-036 Req1 beat with data=101, mask=100: next cycle o_z=1 and o_y/o_x are unchanged.
REQ-037 Req2 beat with lock=1, then req0 valid: o_busy=1, req0 gets no ready until req2 sends lock=0; req0 is then granted on the next cycle.
REQ-038 Req1 locks, then all valids drop: o_timeout pulses exactly LOCK_TIMEOUT cycles after the lock beat; ptr=2; o_busy=0.
REQ-039 i_srst asserted while LOCKED with a beat present: no field update; all outputs take reset values the next cycle.
REQ-040 i_arst pulse between edges: outputs clear without a clock edge; 256 accepted beats return o_wr_count to 0.
